periph_bus_arbiter: RTL and testbench

Shares the single memory-mapped peripheral bus (timer TH/TL/TCON, LED, switch, digit registers at 0x40000000–0x40000014) between two masters: M0, the CPU MEM stage, and M1, the UART/DMA engine. Each access passes through a 3-state sequencer. Arbitration is round-robin with optional bounded locking. Illegal addresses are blocked and flagged. The block sits between the masters and the peripheral block; the peripheral sees exactly one one-cycle rd or wr strobe per accepted transaction.

---
 rtl/periph_bus_pkg.sv | 34 +++
 rtl/rr_pick2.sv | 29 ++
 rtl/periph_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
package periph_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } owner_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

   localparam logic [31:0] OFF_TH     = 32'h00;
   localparam logic [31:0] OFF_TL     = 32'h04;
   localparam logic [31:0] OFF_TCON   = 32'h08;
   localparam logic [31:0] OFF_LED    = 32'h0C;
   localparam logic [31:0] OFF_SWITCH = 32'h10;
   localparam logic [31:0] OFF_DIGI   = 32'h14;

   // Word-aligned and inside the register window; addresses below base wrap
   // to a large offset and are rejected by the range test.
   function automatic logic addr_legal(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input int unsigned nregs);
      logic [31:0] off;
      off = a - base;
      return (off[1:0] == 2'b00) && (off < 32'(4 * nregs));
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-master winner selection: lock first, then round-robin.
module rr_pick2
   import periph_bus_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last_owner,
   input  logic       lock_valid,
   input  owner_t     lock_owner,
   output owner_t     winner,
   output logic       any
);

   // Locked master wins if it requests; otherwise sole requester or the
   // master that did not own the bus last.
   always_comb begin
      any    = |req;
      winner = M0;
      if (lock_valid && req[lock_owner]) begin
         winner = lock_owner;
      end else if (req == 2'b01) begin
         winner = M0;
      end else if (req == 2'b10) begin
         winner = M1;
      end else begin
         winner = (last_owner == M0) ? M1 : M0;
      end
   end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the memory-mapped peripheral bus with a fixed
// IDLE -> ACCESS -> RESP sequence per transaction.
module periph_bus_arbiter
   import periph_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned NUM_REGS  = 6,
   parameter int unsigned LOCK_MAX  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        rd,
   output logic        wr,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata
);

   localparam int unsigned CW = $clog2(LOCK_MAX + 1);

   state_t        state;
   owner_t        owner_q;
   logic [CW-1:0] lock_cnt;
   logic          lock_valid;
   logic          err_l;

   logic [1:0]    req;
   owner_t        winner;
   logic          any;

   logic          sel_wr;
   logic          sel_lock;
   logic [31:0]   sel_addr;
   logic [31:0]   sel_wdata;
   logic          sel_legal;
   logic [CW-1:0] next_cnt;

   assign req = {m1_req, m0_req};

   rr_pick2 u_pick (
      .req        (req),
      .last_owner (owner_q),
      .lock_valid (lock_valid),
      .lock_owner (owner_q),
      .winner     (winner),
      .any        (any)
   );

   // Route the winning master's request fields and precompute legality and
   // the lock count that acceptance would produce.
   always_comb begin
      sel_wr    = (winner == M1) ? m1_wr    : m0_wr;
      sel_lock  = (winner == M1) ? m1_lock  : m0_lock;
      sel_addr  = (winner == M1) ? m1_addr  : m0_addr;
      sel_wdata = (winner == M1) ? m1_wdata : m0_wdata;
      sel_legal = addr_legal(sel_addr, BASE_ADDR, NUM_REGS);
      if (lock_valid && req[owner_q] && (winner == owner_q)) begin
         next_cnt = lock_cnt + CW'(1);
      end else begin
         next_cnt = CW'(1);
      end
   end

   // Sequencer, lock bookkeeping and all registered bus/master outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner_q    <= M1;
         lock_cnt   <= '0;
         lock_valid <= 1'b0;
         err_l      <= 1'b0;
         rd         <= 1'b0;
         wr         <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
         m0_gnt     <= 1'b0;
         m1_gnt     <= 1'b0;
         m0_rvalid  <= 1'b0;
         m1_rvalid  <= 1'b0;
         m0_err     <= 1'b0;
         m1_err     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A lock lapses as soon as its holder stops requesting.
               if (lock_valid && !req[owner_q]) begin
                  lock_valid <= 1'b0;
               end
               if (any) begin
                  state   <= ACCESS;
                  owner_q <= winner;
                  addr    <= sel_addr;
                  wdata   <= sel_wdata;
                  err_l   <= ~sel_legal;
                  rd      <= sel_legal & ~sel_wr;
                  wr      <= sel_legal & sel_wr;
                  m0_gnt  <= (winner == M0);
                  m1_gnt  <= (winner == M1);
                  if (sel_lock) begin
                     lock_cnt   <= next_cnt;
                     lock_valid <= (next_cnt < CW'(LOCK_MAX));
                  end else begin
                     lock_cnt   <= '0;
                     lock_valid <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               // The master rdata registers double as the response register;
               // rd is set only for a legal read, so writes/illegal give 0.
               state     <= RESP;
               rd        <= 1'b0;
               wr        <= 1'b0;
               m0_gnt    <= 1'b0;
               m1_gnt    <= 1'b0;
               m0_rvalid <= (owner_q == M0);
               m1_rvalid <= (owner_q == M1);
               m0_err    <= (owner_q == M0) & err_l;
               m1_err    <= (owner_q == M1) & err_l;
               m0_rdata  <= ((owner_q == M0) && rd) ? rdata : '0;
               m1_rdata  <= ((owner_q == M1) && rd) ? rdata : '0;
            end
            RESP: begin
               state     <= IDLE;
               m0_rvalid <= 1'b0;
               m1_rvalid <= 1'b0;
               m0_err    <= 1'b0;
               m1_err    <= 1'b0;
               m0_rdata  <= '0;
               m1_rdata  <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: single-transaction vector table
// plus hand sequences for alternation, locking and mid-access reset.
module tb_periph_bus_arbiter;
   import periph_bus_pkg::*;

   logic        clk;
   logic        reset;
   logic        m0_req, m0_wr, m0_lock;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_gnt, m0_rvalid, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_wr, m1_lock;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_rdata;
   logic        rd, wr;
   logic [31:0] addr, wdata, rdata;

   int checks;
   int failures;

   periph_bus_arbiter #(
      .BASE_ADDR (32'h4000_0000),
      .NUM_REGS  (6),
      .LOCK_MAX  (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_wr     (m0_wr),
      .m0_lock   (m0_lock),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_err    (m0_err),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_wr     (m1_wr),
      .m1_lock   (m1_lock),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_err    (m1_err),
      .m1_rdata  (m1_rdata),
      .rd        (rd),
      .wr        (wr),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        m;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] prd;
      logic        exp_rd;
      logic        exp_wr;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      m0_req = 0; m0_wr = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_wr = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
      rdata = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic set_m(input logic m, input logic req, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (m) begin
         m1_req = req; m1_wr = w; m1_addr = a; m1_wdata = d;
      end else begin
         m0_req = req; m0_wr = w; m0_addr = a; m0_wdata = d;
      end
   endtask

   // Steps until some grant appears; who = granting master, n = cycles taken.
   task automatic wait_gnt(input string nm, input int budget, output logic who, output int n);
      who = 1'b0;
      n   = 0;
      for (int c = 1; c <= budget; c++) begin
         tick();
         if (m0_gnt || m1_gnt) begin
            n   = c;
            who = m1_gnt;
            chk({nm, "_excl"}, 32'(m0_gnt & m1_gnt), 32'd0);
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL %s: no grant within %0d cycles", nm, budget);
   endtask

   initial begin
      logic who;
      int   n;
      logic exp_seq [6];

      checks   = 0;
      failures = 0;
      clear_inputs();
      reset = 1'b0;

      vecs[0] = '{1'b0, 1'b0, 32'h4000_0010, 32'h0,         32'h5A,        1'b1, 1'b0, 1'b0, 32'h5A};
      vecs[1] = '{1'b0, 1'b0, 32'h4000_0018, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0};
      vecs[2] = '{1'b0, 1'b1, 32'h4000_0002, 32'h1234,      32'hCAFE_0000, 1'b0, 1'b0, 1'b1, 32'h0};
      vecs[3] = '{1'b1, 1'b0, 32'h4000_0008, 32'h0,         32'h5,         1'b1, 1'b0, 1'b0, 32'h5};
      vecs[4] = '{1'b1, 1'b1, 32'h4000_000C, 32'h0000_00FF, 32'h1234,      1'b0, 1'b1, 1'b0, 32'h0};
      vecs[5] = '{1'b0, 1'b0, 32'h3FFF_FFFC, 32'h0,         32'h9999,      1'b0, 1'b0, 1'b1, 32'h0};
      vecs[6] = '{1'b0, 1'b0, 32'h4000_0014, 32'h0,         32'h77,        1'b1, 1'b0, 1'b0, 32'h77};
      vecs[7] = '{1'b1, 1'b1, 32'h4000_0000, 32'hABCD_0123, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0};

      // Reset state
      do_reset();
      chk("rst_rd",     32'(rd), 32'd0);
      chk("rst_wr",     32'(wr), 32'd0);
      chk("rst_addr",   addr,  32'd0);
      chk("rst_wdata",  wdata, 32'd0);
      chk("rst_gnt",    32'({m0_gnt, m1_gnt}), 32'd0);
      chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid, m0_err, m1_err}), 32'd0);
      chk("rst_rdata0", m0_rdata, 32'd0);
      chk("rst_rdata1", m1_rdata, 32'd0);

      // Single-transaction table
      for (int i = 0; i < 8; i++) begin
         set_m(vecs[i].m, 1'b1, vecs[i].w, vecs[i].a, vecs[i].d);
         rdata = vecs[i].prd;
         tick();
         chk($sformatf("v%0d_gnt_own", i),   32'(vecs[i].m ? m1_gnt : m0_gnt), 32'd1);
         chk($sformatf("v%0d_gnt_other", i), 32'(vecs[i].m ? m0_gnt : m1_gnt), 32'd0);
         chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
         chk($sformatf("v%0d_wr", i), 32'(wr), 32'(vecs[i].exp_wr));
         if (vecs[i].exp_rd || vecs[i].exp_wr)
            chk($sformatf("v%0d_addr", i), addr, vecs[i].a);
         if (vecs[i].exp_wr)
            chk($sformatf("v%0d_wdata", i), wdata, vecs[i].d);
         set_m(vecs[i].m, 1'b0, 1'b0, '0, '0);
         tick();
         chk($sformatf("v%0d_rvalid_own", i),   32'(vecs[i].m ? m1_rvalid : m0_rvalid), 32'd1);
         chk($sformatf("v%0d_rvalid_other", i), 32'(vecs[i].m ? m0_rvalid : m1_rvalid), 32'd0);
         chk($sformatf("v%0d_err", i),   32'(vecs[i].m ? m1_err : m0_err), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_rdata", i), vecs[i].m ? m1_rdata : m0_rdata, vecs[i].exp_rdata);
         chk($sformatf("v%0d_rdata_other", i), vecs[i].m ? m0_rdata : m1_rdata, 32'd0);
         chk($sformatf("v%0d_resp_strobes", i), 32'({rd, wr}), 32'd0);
         tick();
         chk($sformatf("v%0d_rvalid_end", i), 32'({m0_rvalid, m1_rvalid}), 32'd0);
      end

      // Continuous writes from both masters, no lock: strict alternation
      do_reset();
      m0_req = 1; m0_wr = 1; m0_addr = DEFAULT_BASE_ADDR + OFF_LED;  m0_wdata = 32'hA0A0_0001;
      m1_req = 1; m1_wr = 1; m1_addr = DEFAULT_BASE_ADDR + OFF_DIGI; m1_wdata = 32'hB1B1_0002;
      for (int k = 0; k < 4; k++) begin
         wait_gnt($sformatf("alt%0d", k), 10, who, n);
         chk($sformatf("alt%0d_owner", k), 32'(who), 32'(k % 2));
         if (k > 0) chk($sformatf("alt%0d_spacing", k), 32'(n), 32'd3);
         chk($sformatf("alt%0d_wr", k), 32'(wr), 32'd1);
         chk($sformatf("alt%0d_wdata", k), wdata, (k % 2) ? 32'hB1B1_0002 : 32'hA0A0_0001);
         chk($sformatf("alt%0d_addr", k), addr, (k % 2) ? 32'h4000_0014 : 32'h4000_000C);
      end
      clear_inputs();
      repeat (3) tick();

      // Locked M1 against a continuously requesting M0
      do_reset();
      m1_req = 1; m1_lock = 1; m1_wr = 0; m1_addr = DEFAULT_BASE_ADDR + OFF_TH;
      rdata = 32'h11;
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 6; k++) begin
         wait_gnt($sformatf("lock%0d", k), 10, who, n);
         chk($sformatf("lock%0d_owner", k), 32'(who), 32'(exp_seq[k]));
         if (k == 0) begin
            m0_req = 1; m0_wr = 0; m0_addr = DEFAULT_BASE_ADDR + OFF_TL;
         end
      end
      clear_inputs();
      repeat (3) tick();

      // Reset asserted during the ACCESS cycle of an M1 write
      do_reset();
      m1_req = 1; m1_wr = 1; m1_addr = DEFAULT_BASE_ADDR + OFF_LED; m1_wdata = 32'h3C;
      wait_gnt("rstmid", 10, who, n);
      chk("rstmid_owner", 32'(who), 32'd1);
      chk("rstmid_wr_pre", 32'(wr), 32'd1);
      reset = 1'b1;
      #1;
      chk("rstmid_wr_drop", 32'(wr), 32'd0);
      chk("rstmid_gnt_drop", 32'(m1_gnt), 32'd0);
      m1_req = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rstmid_no_rvalid%0d", k), 32'(m1_rvalid), 32'd0);
         tick();
      end
      m0_req = 1; m0_addr = DEFAULT_BASE_ADDR + OFF_SWITCH;
      m1_req = 1; m1_addr = DEFAULT_BASE_ADDR + OFF_TCON;
      wait_gnt("rstmid_tie", 10, who, n);
      chk("rstmid_tie_owner", 32'(who), 32'd0);
      clear_inputs();
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
